// File: rtl/ws_sta_drain_16x16x1x4x1_if.sv
// Bundle for the drain stage: the skewed partial-sum input from the systolic
// array, and the valid/ready row output with its status flags.
interface ws_sta_drain_16x16x1x4x1_if #(
   parameter int unsigned LANES = 64,
   parameter int unsigned W_IN  = 20,
   parameter int unsigned W_ACC = 24
);
   logic                   in_valid;
   logic                   in_last;
   logic [LANES*W_IN-1:0]  in_c;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*W_ACC-1:0] out_data;
   logic                   out_sat;
   logic                   overrun;
   logic                   busy;

   // Producer/consumer side: drives the array beats and the output accept
   modport master (
      output in_valid, in_last, in_c, out_ready,
      input  out_valid, out_data, out_sat, overrun, busy
   );

   // Drain side
   modport slave (
      input  in_valid, in_last, in_c, out_ready,
      output out_valid, out_data, out_sat, overrun, busy
   );
endinterface

// File: rtl/ws_sta_drain_16x16x1x4x1.sv
// Output drain for the 16x16x1x4x1 weight-stationary array: deskews the 64
// partial-sum lanes, accumulates rows across K-tiles with signed saturation,
// and queues completed rows in a 2-entry valid/ready FIFO. The input is never
// stalled; a row that finds the FIFO full is dropped and flagged in overrun.
module ws_sta_drain_16x16x1x4x1 #(
   parameter int unsigned LANES = 64,
   parameter int unsigned GROUP = 4,
   parameter int unsigned W_IN  = 20,
   parameter int unsigned W_ACC = 24
) (
   input logic                        clock,
   input logic                        reset,
   ws_sta_drain_16x16x1x4x1_if.slave  bus
);
   localparam int unsigned NG  = LANES / GROUP;
   localparam int unsigned DLY = NG - 1;
   localparam int unsigned GW  = GROUP * W_IN;
   localparam int unsigned RW  = LANES * W_ACC;
   localparam logic [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
   localparam logic [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

   // Control delay line (stage DLY-1 is the aligned stage D)
   logic [DLY-1:0] vld_q, vld_d;
   logic [DLY-1:0] lst_q, lst_d;

   // Per-group live flag: group g holds row data exactly g cycles after in_valid
   logic [NG-1:0]  grp_live;
   logic [GW-1:0]  grp_al [NG];
   logic           d_valid;
   logic           d_last;

   // Accumulators
   logic [W_ACC-1:0] acc_q [LANES];
   logic [W_ACC-1:0] acc_d [LANES];
   logic             sat_q, sat_d;
   logic [W_ACC-1:0] sum_c [LANES];
   logic [RW-1:0]    row_pk_c;
   logic             row_sat_c;
   logic             acc_nz_c;
   logic             push_c;

   // Output FIFO
   logic [RW-1:0] fdat_q [2];
   logic [RW-1:0] fdat_d [2];
   logic [1:0]    fsat_q, fsat_d;
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          ovr_q, ovr_d;
   logic          pop_c;
   logic          accept_c;

   assign grp_live = {vld_q, bus.in_valid};
   assign d_valid  = vld_q[DLY-1];
   assign d_last   = lst_q[DLY-1];

   // Shift in_valid/in_last down the control line so they meet the deskewed data
   always_comb begin
      vld_d = {vld_q[DLY-2:0], bus.in_valid};
      lst_d = {lst_q[DLY-2:0], bus.in_last};
   end

   // Group g is delayed NG-1-g stages; beats are zeroed when no row is in flight
   for (genvar g = 0; g < NG; g++) begin : g_grp
      localparam int unsigned L = NG - 1 - g;
      if (L == 0) begin : g_direct
         assign grp_al[g] = grp_live[g] ? bus.in_c[g*GW +: GW] : '0;
      end else begin : g_line
         logic [GW-1:0] line_q [L];
         logic [GW-1:0] line_d [L];

         // Capture a live group beat and shift it toward stage D
         always_comb begin
            line_d[0] = grp_live[g] ? bus.in_c[g*GW +: GW] : '0;
            for (int unsigned k = 1; k < L; k++) begin
               line_d[k] = line_q[k-1];
            end
         end

         // Deskew registers for this group
         always_ff @(posedge clock) begin
            if (reset) begin
               line_q <= '{default: '0};
            end else begin
               line_q <= line_d;
            end
         end

         assign grp_al[g] = line_q[L-1];
      end
   end

   // Per-lane saturating add of the aligned beat into its running sum
   always_comb begin
      logic [W_IN-1:0] lane;
      logic [W_ACC:0]  wide;
      lane      = '0;
      wide      = '0;
      sum_c     = '{default: '0};
      row_pk_c  = '0;
      row_sat_c = sat_q;
      acc_nz_c  = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane = grp_al[i / GROUP][(i % GROUP) * W_IN +: W_IN];
         wide = {acc_q[i][W_ACC-1], acc_q[i]} + {{(W_ACC+1-W_IN){lane[W_IN-1]}}, lane};
         if (wide[W_ACC] != wide[W_ACC-1]) begin
            sum_c[i]  = wide[W_ACC] ? ACC_MIN : ACC_MAX;
            row_sat_c = 1'b1;
         end else begin
            sum_c[i] = wide[W_ACC-1:0];
         end
         row_pk_c[i*W_ACC +: W_ACC] = sum_c[i];
         acc_nz_c = acc_nz_c | (|acc_q[i]);
      end
   end

   // A last beat commits the row and clears the running state; others accumulate
   always_comb begin
      acc_d  = acc_q;
      sat_d  = sat_q;
      push_c = 1'b0;
      if (d_valid) begin
         if (d_last) begin
            acc_d  = '{default: '0};
            sat_d  = 1'b0;
            push_c = 1'b1;
         end else begin
            acc_d = sum_c;
            sat_d = row_sat_c;
         end
      end
   end

   // FIFO bookkeeping; when full wr_q == rd_q, so a same-edge pop+commit
   // writes the new row into the slot the departing head is vacating
   always_comb begin
      pop_c    = (cnt_q != 2'd0) & bus.out_ready;
      accept_c = push_c & ((cnt_q != 2'd2) | pop_c);
      fdat_d   = fdat_q;
      fsat_d   = fsat_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q + {1'b0, accept_c} - {1'b0, pop_c};
      ovr_d    = ovr_q | (push_c & ~accept_c);
      if (accept_c) begin
         fdat_d[wr_q] = row_pk_c;
         fsat_d[wr_q] = row_sat_c;
         wr_d         = ~wr_q;
      end
      if (pop_c) begin
         rd_d = ~rd_q;
      end
   end

   // Control line, accumulator and FIFO state
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q  <= '0;
         lst_q  <= '0;
         acc_q  <= '{default: '0};
         sat_q  <= 1'b0;
         fdat_q <= '{default: '0};
         fsat_q <= '0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         cnt_q  <= '0;
         ovr_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         lst_q  <= lst_d;
         acc_q  <= acc_d;
         sat_q  <= sat_d;
         fdat_q <= fdat_d;
         fsat_q <= fsat_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         ovr_q  <= ovr_d;
      end
   end

   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.out_data  = fdat_q[rd_q];
   assign bus.out_sat   = fsat_q[rd_q];
   assign bus.overrun   = ovr_q;
   assign bus.busy      = (|vld_q) | acc_nz_c;

endmodule

// File: tb/tb_ws_sta_drain_16x16x1x4x1.sv
// Bench for the drain stage: rows are described as whole 64-lane tiles, the
// bench applies the array skew itself, and a row-level model (integer
// accumulators, a queue for the FIFO) predicts every output cycle by cycle.
module tb_ws_sta_drain_16x16x1x4x1;
   localparam int unsigned LANES = 64;
   localparam int unsigned GROUP = 4;
   localparam int unsigned W_IN  = 20;
   localparam int unsigned W_ACC = 24;
   localparam int unsigned NG    = LANES / GROUP;
   localparam int unsigned RW    = LANES * W_ACC;
   localparam int AMAX = 8388607;
   localparam int AMIN = -8388608;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ws_sta_drain_16x16x1x4x1_if #(.LANES(LANES), .W_IN(W_IN), .W_ACC(W_ACC)) bus ();

   ws_sta_drain_16x16x1x4x1 #(.LANES(LANES), .GROUP(GROUP), .W_IN(W_IN), .W_ACC(W_ACC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Row history (ring of issue cycles) and model state
   int      cyc;
   bit      hv [32];
   bit      hl [32];
   int      hd [32][64];
   int      macc [64];
   bit      msat;
   bit      movr;
   logic [RW-1:0] qd [$];
   bit      qs [$];

   int pat [64];
   bit rdy;
   bit rst;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_data(input logic [RW-1:0] exp);
      int bad;
      n_cmp++;
      assert (bus.out_data === exp) else begin
         n_err++;
         bad = 0;
         for (int i = LANES - 1; i >= 0; i--) begin
            if (bus.out_data[i*W_ACC +: W_ACC] !== exp[i*W_ACC +: W_ACC]) bad = i;
         end
         $error("FAIL out_data: lane %0d observed %h expected %h (cycle %0d)", bad,
                bus.out_data[bad*W_ACC +: W_ACC], exp[bad*W_ACC +: W_ACC], cyc);
      end
   endtask

   // Row-level effect of one clock edge
   task automatic model_edge();
      int s;
      int t;
      bit pop;
      bit push;
      bit nsat;
      logic [RW-1:0] pk;
      if (rst) begin
         for (int k = 0; k < 32; k++) hv[k] = 1'b0;
         for (int i = 0; i < 64; i++) macc[i] = 0;
         msat = 1'b0;
         movr = 1'b0;
         qd.delete();
         qs.delete();
      end else begin
         pop  = (qd.size() > 0) && rdy;
         push = 1'b0;
         pk   = '0;
         s    = (cyc - 15) % 32;
         if (cyc >= 15 && hv[s]) begin
            nsat = msat;
            for (int i = 0; i < 64; i++) begin
               t = macc[i] + hd[s][i];
               if (t > AMAX) begin t = AMAX; nsat = 1'b1; end
               if (t < AMIN) begin t = AMIN; nsat = 1'b1; end
               macc[i] = t;
               pk[i*W_ACC +: W_ACC] = 24'(t);
            end
            msat = nsat;
            if (hl[s]) begin
               if (qd.size() == 2 && !pop) movr = 1'b1;
               else push = 1'b1;
               for (int i = 0; i < 64; i++) macc[i] = 0;
               msat = 1'b0;
            end
         end
         if (pop) begin
            void'(qd.pop_front());
            void'(qs.pop_front());
         end
         if (push) begin
            qd.push_back(pk);
            qs.push_back(nsat);
         end
      end
   endtask

   task automatic check_outputs();
      bit b;
      int c0;
      chk("out_valid", bus.out_valid, qd.size() > 0);
      if (qd.size() > 0) begin
         chk_data(qd[0]);
         chk("out_sat", bus.out_sat, qs[0]);
      end
      chk("overrun", bus.overrun, movr);
      b = 1'b0;
      for (int k = 0; k < 15; k++) begin
         c0 = cyc - 1 - k;
         if (c0 >= 0 && hv[c0 % 32]) b = 1'b1;
      end
      for (int i = 0; i < 64; i++) if (macc[i] != 0) b = 1'b1;
      chk("busy", bus.busy, b);
      if (rst) begin
         chk_data('0);
         chk("out_sat_rst", bus.out_sat, 0);
      end
   endtask

   // One cycle: issue (or not) a row from pat, drive the skewed bus, clock, check
   task automatic tick(input bit v, input bit l);
      int s;
      int src;
      logic [W_IN-1:0] lv;
      s = cyc % 32;
      hv[s] = v;
      hl[s] = l;
      if (v) for (int i = 0; i < 64; i++) hd[s][i] = pat[i];
      bus.in_valid  = v;
      bus.in_last   = v ? l : 1'($urandom);
      bus.out_ready = rdy;
      reset         = rst;
      for (int g = 0; g < int'(NG); g++) begin
         src = cyc - g;
         for (int j = 0; j < int'(GROUP); j++) begin
            if (src >= 0 && hv[src % 32]) lv = 20'(hd[src % 32][g*GROUP + j]);
            else lv = 20'($urandom);
            bus.in_c[(g*GROUP + j)*W_IN +: W_IN] = lv;
         end
      end
      @(posedge clock);
      #1;
      model_edge();
      cyc++;
      check_outputs();
   endtask

   task automatic rand_pat();
      for (int i = 0; i < 64; i++) begin
         case ($urandom % 8)
            0:       pat[i] = 524287;
            1:       pat[i] = -524288;
            default: pat[i] = int'($urandom_range(0, 1048575)) - 524288;
         endcase
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int first;
      int nval;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_c      = '0;
      bus.out_ready = 1'b0;
      cyc  = 0;
      msat = 1'b0;
      movr = 1'b0;
      for (int k = 0; k < 32; k++) begin hv[k] = 1'b0; hl[k] = 1'b0; end
      for (int i = 0; i < 64; i++) begin macc[i] = 0; pat[i] = 0; end

      // Reset state
      rdy = 1'b1; rst = 1'b1;
      tick(0, 0); tick(0, 0);
      rst = 1'b0;

      // Single tile: lane i = i+1, latency and one-cycle output
      for (int i = 0; i < 64; i++) pat[i] = i + 1;
      t0 = cyc; first = -1; nval = 0;
      tick(1, 1);
      repeat (20) begin
         tick(0, 0);
         if (bus.out_valid === 1'b1) begin
            if (first < 0) first = cyc;
            nval++;
         end
      end
      chk("latency", first - t0, 16);
      chk("single_valid_cycles", nval, 1);

      // Three-tile accumulation with negatives, then a fresh single tile
      for (int j = 1; j <= 3; j++) begin
         for (int i = 0; i < 64; i++) pat[i] = i + j - 5;
         tick(1, j == 3);
      end
      for (int i = 0; i < 64; i++) pat[i] = i + 1;
      tick(1, 1);
      repeat (20) tick(0, 0);

      // Saturation both ways, an unsaturated follower, and a 10-tile sum
      for (int i = 0; i < 64; i++) pat[i] = 524287;
      repeat (19) tick(1, 0);
      tick(1, 1);
      for (int i = 0; i < 64; i++) pat[i] = -3;
      tick(1, 1);
      for (int i = 0; i < 64; i++) pat[i] = -524288;
      repeat (19) tick(1, 0);
      tick(1, 1);
      for (int i = 0; i < 64; i++) pat[i] = 524287;
      repeat (9) tick(1, 0);
      tick(1, 1);
      repeat (20) tick(0, 0);

      // Backpressure: three rows into a stalled 2-entry FIFO, then drain
      rdy = 1'b0;
      repeat (3) begin rand_pat(); tick(1, 1); end
      repeat (20) tick(0, 0);
      chk("overrun_after_drop", bus.overrun, 1);
      rdy = 1'b1;
      repeat (4) tick(0, 0);

      // Pop and commit on the same edge while full
      rst = 1'b1; tick(0, 0); rst = 1'b0;
      rdy = 1'b0;
      repeat (3) begin rand_pat(); tick(1, 1); end
      repeat (14) tick(0, 0);
      rdy = 1'b1; tick(0, 0);
      rdy = 1'b0; tick(0, 0); tick(0, 0);
      chk("overrun_pop_commit", bus.overrun, 0);
      rdy = 1'b1;
      repeat (4) tick(0, 0);

      // Reset mid-flight, then a new row
      rand_pat(); tick(1, 1);
      repeat (7) tick(0, 0);
      rst = 1'b1; tick(0, 0); rst = 1'b0;
      repeat (3) tick(0, 0);
      rand_pat(); tick(1, 1);
      repeat (20) tick(0, 0);

      // Sixteen back-to-back rows
      rdy = 1'b1; nval = 0;
      for (int r = 0; r < 36; r++) begin
         for (int i = 0; i < 64; i++) pat[i] = r * 64 + i;
         tick(r < 16, 1);
         if (bus.out_valid === 1'b1) nval++;
      end
      chk("b2b_outputs", nval, 16);

      // Random traffic with occasional resets
      repeat (400) begin
         rand_pat();
         rdy = ($urandom % 4) != 0;
         rst = ($urandom % 150) == 0;
         tick(($urandom % 3) != 0, ($urandom % 3) == 0);
      end
      rst = 1'b0; rdy = 1'b1;
      repeat (24) tick(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
